pic_cycle_sequencer: RTL and testbench
======================================

# pic_cycle_sequencer

Parametrised instruction-cycle sequencer for the PIC16C5x-class core. It replaces the fixed Q1–Q4 control unit. It generates the four-phase cycle with an optional stretched Q2 for slow program memory, latches the fetched instruction, and decodes the ALU function. It also handles two-cycle instructions: GOTO/CALL/RETLW flushes and taken FSZ/BTFSx skips become forced NOP cycles. SLEEP/wake support is optional. It sits between program memory, the PC/stack unit, the ALU and the register file.

## Interface
- `INST_WIDTH`, 12 — instruction width; decode uses bits [11:0].
- `ALU_FUNC_WIDTH`, 5 — width of `alu_func`; codes come from the shared `ALU_*` definitions.
- `WAIT_STATES`, 0 — extra clocks inserted in Q2. Legal range 0..7.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `inst_in`  in  INST_WIDTH  program-memory data; sampled on the last Q4 clock.
- `skip_cond`  in  1  ALU zero / bit-test result; valid during Q4.
- `wake`  in  1  wake request (level).
- `phase`  out  4  one-hot phase {Q4,Q3,Q2,Q1}.
- `ir`  out  INST_WIDTH  instruction being executed.
- `ex_valid`  out  1  the current cycle executes `ir`. When 0, the cycle is a forced NOP.
- `pc_inc`  out  1  single-clock pulse on the first Q1 clock.
- `alu_func`  out  ALU_FUNC_WIDTH  ALU function; loaded on entry to Q3.
- `alu_en`  out  1  high for the whole Q3 phase when `ex_valid`.
- `pc_load`  out  1  single Q4 clock for a valid GOTO, CALL or RETLW.
- `stack_push`, `stack_pop`  out  1  single Q4 clock for a valid CALL or RETLW, respectively.
- `sleeping`  out  1  core is halted.

## Operation
- **Phase FSM:** Q1 → Q2 → Q3 → Q4 → Q1.
  - Q2 lasts 1+WAIT_STATES clocks; the wait counter clears on entry to Q2.
  - Every other phase lasts one clock.
- **Instruction latch:** on the last Q4 clock, `ir` ← `inst_in`.
- **Flush:** `ex_valid` for the next cycle ← !flush_req. flush_req = valid GOTO (101x), CALL (1001) or RETLW (1000), or a valid DECFSZ/INCFSZ/BTFSC/BTFSS with `skip_cond`=1. BTFSC skips on `skip_cond`=1; the ALU presents the tested bit as a normalised condition.
- **ALU decode:** combinational from `ir` in Q2, registered on the Q2→Q3 edge.
  - ADDWF, ANDWF, COMF, DECF/DECFSZ→DECF, INCF/INCFSZ→INCF, IORWF, RLF, RRF, SUBWF, SWAPF, XORWF, BCF, BSF, ANDLW, IORLW and XORLW map to their named codes.
  - Everything else maps to ALU_IDLE.
  - When `ex_valid`=0, the decoded value is ALU_IDLE.
  - `alu_func` holds its value until the next Q3 entry.
- **Side-effect strobes:** `pc_load`, `stack_push` and `stack_pop` are gated by `ex_valid`. They are never asserted in a NOP cycle.
- **Sleep:** a valid SLEEP (0000_0000_0011) at Q4 sets `sleeping`.
  - The FSM parks in Q1 with `pc_inc` suppressed. `ir` already holds the next instruction.
  - `wake`=1 while sleeping clears `sleeping` on that edge. The next clock is Q1 with `pc_inc`=1, and the held instruction then executes normally.
  - `wake` while not sleeping has no effect.

## Timing
- **Reset values:** `phase`=0001 (Q1), `ir`=0, `ex_valid`=0 (the first cycle is a NOP), `pc_inc`=1 on the first clock after reset is released, `alu_func`=ALU_IDLE, `alu_en`=0, `pc_load`=`stack_push`=`stack_pop`=0, `sleeping`=0, wait counter=0.
- **Cycle length:** 4+WAIT_STATES clocks. `ir` is usable from the first Q1 clock following the fetch.
- **Flush latency:** a branch or taken skip in cycle N makes cycle N+1 a NOP. Cycle N+2 executes the target or the instruction after the skipped one.
- **Simultaneous events:**
  - SLEEP and `wake` high in the same Q4: sleep is entered, and `wake` is honoured on the following clock.
  - A flush request coincident with SLEEP is impossible, since they are distinct opcodes.
- **Reset priority:** `rst` has priority everywhere, including mid-Q2 wait and during sleep. It returns all registers to their reset values on the same edge.
- **Invalid phase encoding:** an illegal encoding (only reachable via SEU or X) recovers to Q1 on the next clock, with `ex_valid`=0.

## Configuration
- **`PIC_SEQ_SLEEP_EN` defined:** sleep and wake behave as described above.
- **`PIC_SEQ_SLEEP_EN` undefined:**
  - SLEEP decodes as a plain NOP, and `sleeping` is tied to 0.
  - `wake` is ignored and the sleep register is not instantiated.

## Test plan
- **Reset and idle cycle:** assert `rst` for 3 clocks with WAIT_STATES=0, then release it and feed ADDWF 0x1C3 → `phase` sequence 1,2,4,8,1; `ex_valid`=0 in the first cycle; in the second cycle `alu_func`=ALU_ADDWF and `alu_en` is high for exactly 1 clock.
- **Wait states:** set WAIT_STATES=3 → Q2 holds for 4 clocks, cycle length is 7 clocks, and `pc_inc` pulses every 7 clocks.
- **GOTO flush:** feed GOTO 0xA05 followed by ANDLW 0xE0F → `pc_load` pulses once at Q4; the ANDLW cycle has `ex_valid`=0, `alu_func`=ALU_IDLE and no `alu_en`.
- **Skip taken and not taken:**
  - DECFSZ 0x2C4 with `skip_cond`=1 → the next cycle is a NOP.
  - The same DECFSZ with `skip_cond`=0 → the next cycle executes.
  - In both cases `alu_func`=ALU_DECF.
- **BSF decode:** feed BSF 0x5A3 → `alu_func`=ALU_BSF; feed BCF 0x4A3 → `alu_func`=ALU_BCF.
- **Sleep and wake** (PIC_SEQ_SLEEP_EN defined):
  - Feed 0x003 → `sleeping`=1 and `phase` stays at 0001 for 20 clocks with no `pc_inc`.
  - Pulse `wake` → `pc_inc` fires on the next clock, and the held instruction executes with `ex_valid`=1.
  - Assert `rst` mid-sleep → `sleeping`=0 on the same edge.

Source files
------------

// File: rtl/pic_cycle_sequencer.sv
// pic_cycle_sequencer
// Four-phase (Q1..Q4) instruction-cycle sequencer for a PIC16C5x-class core.
// It stretches Q2 by WAIT_STATES clocks for slow program memory. It latches
// the fetched instruction and decodes the ALU function. A taken branch or
// skip turns the following cycle into a forced NOP.
//
// Optional SLEEP/wake support is enabled by defining PIC_SEQ_SLEEP_EN.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   inst_in       program-memory data, sampled on the Q4 clock
//   skip_cond     ALU zero / normalised bit-test result, valid in Q4
//   wake          level wake request (only used with PIC_SEQ_SLEEP_EN)
//   phase         one-hot {Q4,Q3,Q2,Q1}
//   ir            instruction being executed
//   ex_valid      current cycle executes ir (0 = forced NOP)
//   pc_inc        PC increment strobe on the Q1 clock
//   alu_func      ALU function, loaded on entry to Q3
//   alu_en        ALU enable through Q3 of a valid cycle
//   pc_load       Q4 strobe for a valid GOTO/CALL/RETLW
//   stack_push    Q4 strobe for a valid CALL
//   stack_pop     Q4 strobe for a valid RETLW
//   sleeping      core halted by SLEEP
module pic_cycle_sequencer #(
    parameter int INST_WIDTH     = 12,
    parameter int ALU_FUNC_WIDTH = 5,
    parameter int WAIT_STATES    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INST_WIDTH-1:0]     inst_in,
    input  logic                      skip_cond,
    input  logic                      wake,
    output logic [3:0]                phase,
    output logic [INST_WIDTH-1:0]     ir,
    output logic                      ex_valid,
    output logic                      pc_inc,
    output logic [ALU_FUNC_WIDTH-1:0] alu_func,
    output logic                      alu_en,
    output logic                      pc_load,
    output logic                      stack_push,
    output logic                      stack_pop,
    output logic                      sleeping
);

    // Shared ALU function codes
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IDLE  = 'd0;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ADDWF = 'd1;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ANDWF = 'd2;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_COMF  = 'd3;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_DECF  = 'd4;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_INCF  = 'd5;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IORWF = 'd6;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_RLF   = 'd7;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_RRF   = 'd8;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_SUBWF = 'd9;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_SWAPF = 'd10;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_XORWF = 'd11;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BCF   = 'd12;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BSF   = 'd13;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ANDLW = 'd14;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IORLW = 'd15;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_XORLW = 'd16;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

    typedef enum logic [3:0] {
        Q1 = 4'b0001,
        Q2 = 4'b0010,
        Q3 = 4'b0100,
        Q4 = 4'b1000
    } phaseT;

    phaseT      state, stateNxt;
    logic       phaseLegal;
    logic [2:0] waitCnt;
    logic       waitDone;
    logic [11:0] op;
    logic [ALU_FUNC_WIDTH-1:0] aluDec;
    logic       isGoto, isCall, isRetlw, isSkip, flushReq;

    assign op       = ir[11:0];
    assign waitDone = (waitCnt == WAIT_LAST);

    assign isGoto  = (op[11:9] == 3'b101);
    assign isCall  = (op[11:8] == 4'b1001);
    assign isRetlw = (op[11:8] == 4'b1000);
    // DECFSZ, INCFSZ, BTFSC, BTFSS
    assign isSkip  = (op[11:6] == 6'b001011) || (op[11:6] == 6'b001111) ||
                     (op[11:9] == 3'b011);
    assign flushReq = ex_valid && (isGoto || isCall || isRetlw || (isSkip && skip_cond));

    // Phase FSM next state; sleeping parks the machine in Q1
    always_comb begin
        stateNxt   = Q1;
        phaseLegal = 1'b1;
        case (state)
            Q1:      stateNxt = sleeping ? Q1 : Q2;
            Q2:      stateNxt = waitDone ? Q3 : Q2;
            Q3:      stateNxt = Q4;
            Q4:      stateNxt = Q1;
            default: begin
                stateNxt   = Q1;
                phaseLegal = 1'b0;
            end
        endcase
    end

    // ALU decode of the byte/bit/literal-oriented groups
    always_comb begin
        aluDec = ALU_IDLE;
        if (op[11:10] == 2'b00) begin
            case (op[9:6])
                4'b0010: aluDec = ALU_SUBWF;
                4'b0011: aluDec = ALU_DECF;
                4'b0100: aluDec = ALU_IORWF;
                4'b0101: aluDec = ALU_ANDWF;
                4'b0110: aluDec = ALU_XORWF;
                4'b0111: aluDec = ALU_ADDWF;
                4'b1001: aluDec = ALU_COMF;
                4'b1010: aluDec = ALU_INCF;
                4'b1011: aluDec = ALU_DECF;   // DECFSZ
                4'b1100: aluDec = ALU_RRF;
                4'b1101: aluDec = ALU_RLF;
                4'b1110: aluDec = ALU_SWAPF;
                4'b1111: aluDec = ALU_INCF;   // INCFSZ
                default: aluDec = ALU_IDLE;
            endcase
        end else begin
            case (op[11:8])
                4'b0100: aluDec = ALU_BCF;
                4'b0101: aluDec = ALU_BSF;
                4'b1101: aluDec = ALU_IORLW;
                4'b1110: aluDec = ALU_ANDLW;
                4'b1111: aluDec = ALU_XORLW;
                default: aluDec = ALU_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= Q1;
            waitCnt  <= 3'd0;
            ir       <= '0;
            ex_valid <= 1'b0;
            alu_func <= ALU_IDLE;
        end else begin
            state <= stateNxt;
            // Counter is held at zero outside Q2 so every Q2 entry starts fresh
            if (state != Q2)
                waitCnt <= 3'd0;
            else if (!waitDone)
                waitCnt <= waitCnt + 3'd1;
            if (state == Q2 && waitDone)
                alu_func <= ex_valid ? aluDec : ALU_IDLE;
            if (state == Q4) begin
                ir       <= inst_in;
                ex_valid <= !flushReq;
            end
            if (!phaseLegal)
                ex_valid <= 1'b0;
        end
    end

`ifdef PIC_SEQ_SLEEP_EN
    logic isSleep;
    assign isSleep = ex_valid && (op == 12'h003);

    // Wake is only examined while sleeping; a same-edge SLEEP+wake therefore
    // enters sleep first and wakes one clock later.
    always_ff @(posedge clk) begin
        if (rst)
            sleeping <= 1'b0;
        else if (sleeping && wake)
            sleeping <= 1'b0;
        else if (state == Q4 && isSleep)
            sleeping <= 1'b1;
    end
`else
    logic unusedWake;
    assign unusedWake = wake;
    assign sleeping   = 1'b0;
`endif

    assign phase      = state;
    assign pc_inc     = (state == Q1) && !sleeping;
    assign alu_en     = (state == Q3) && ex_valid;
    assign pc_load    = (state == Q4) && ex_valid && (isGoto || isCall || isRetlw);
    assign stack_push = (state == Q4) && ex_valid && isCall;
    assign stack_pop  = (state == Q4) && ex_valid && isRetlw;

endmodule

// File: tb/tb_pic_cycle_sequencer.sv
// Directed testbench for pic_cycle_sequencer. dut0 uses WAIT_STATES=0 and
// runs the instruction stream; dut1 uses WAIT_STATES=3 and is used for the
// stretched-Q2 timing at the end. Sleep checks follow PIC_SEQ_SLEEP_EN.
module tb_pic_cycle_sequencer;

    localparam logic [4:0] A_IDLE  = 5'd0;
    localparam logic [4:0] A_ADDWF = 5'd1;
    localparam logic [4:0] A_DECF  = 5'd4;
    localparam logic [4:0] A_BCF   = 5'd12;
    localparam logic [4:0] A_BSF   = 5'd13;
    localparam logic [4:0] A_XORLW = 5'd16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] instIn = 12'h000;
    logic        skipCond = 1'b0;
    logic        wake = 1'b0;

    logic [3:0]  phase0, phase1;
    logic [11:0] ir0, ir1;
    logic        exv0, exv1, pcInc0, pcInc1, aluEn0, aluEn1;
    logic [4:0]  alu0, alu1;
    logic        pcLoad0, pcLoad1, push0, push1, pop0, pop1, slp0, slp1;

    int checks = 0;
    int failures = 0;

    pic_cycle_sequencer #(.INST_WIDTH(12), .ALU_FUNC_WIDTH(5), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .inst_in(instIn), .skip_cond(skipCond), .wake(wake),
        .phase(phase0), .ir(ir0), .ex_valid(exv0), .pc_inc(pcInc0), .alu_func(alu0),
        .alu_en(aluEn0), .pc_load(pcLoad0), .stack_push(push0), .stack_pop(pop0),
        .sleeping(slp0)
    );

    pic_cycle_sequencer #(.INST_WIDTH(12), .ALU_FUNC_WIDTH(5), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .inst_in(instIn), .skip_cond(skipCond), .wake(wake),
        .phase(phase1), .ir(ir1), .ex_valid(exv1), .pc_inc(pcInc1), .alu_func(alu1),
        .alu_en(aluEn1), .pc_load(pcLoad1), .stack_push(push1), .stack_pop(pop1),
        .sleeping(slp1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] expPh [14] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h8, 4'h1,
                               4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h8, 4'h1};

    initial begin
        // Reset held 3 clocks
        tick(); tick(); tick();
        check("rst_phase", 32'(phase0), 32'h1);
        check("rst_ir", 32'(ir0), 32'h0);
        check("rst_exv", 32'(exv0), 32'h0);
        check("rst_alu", 32'(alu0), 32'(A_IDLE));
        check("rst_aluen", 32'(aluEn0), 32'h0);
        check("rst_strobes", 32'({pcLoad0, push0, pop0}), 32'h0);
        check("rst_sleep", 32'(slp0), 32'h0);

        rst = 1'b0; instIn = 12'h1C3;               // ADDWF
        check("c0_q1_phase", 32'(phase0), 32'h1);
        check("c0_pcinc", 32'(pcInc0), 32'h1);
        check("c0_exv", 32'(exv0), 32'h0);
        tick(); check("c0_q2", 32'(phase0), 32'h2);
        tick(); check("c0_q3", 32'(phase0), 32'h4);
        check("c0_aluen", 32'(aluEn0), 32'h0);
        tick(); check("c0_q4", 32'(phase0), 32'h8);
        tick(); check("c1_q1", 32'(phase0), 32'h1);
        check("c1_ir", 32'(ir0), 32'h1C3);
        check("c1_exv", 32'(exv0), 32'h1);
        check("c1_pcinc", 32'(pcInc0), 32'h1);
        instIn = 12'hA05;                            // GOTO

        tick(); check("c1_q2_pcinc", 32'(pcInc0), 32'h0);
        tick(); check("addwf_alu", 32'(alu0), 32'(A_ADDWF));
        check("addwf_aluen", 32'(aluEn0), 32'h1);
        tick(); check("addwf_aluen_q4", 32'(aluEn0), 32'h0);
        tick(); check("goto_ir", 32'(ir0), 32'hA05);
        instIn = 12'hE0F;                            // ANDLW, to be flushed

        tick(); tick(); check("goto_alu", 32'(alu0), 32'(A_IDLE));
        tick(); check("goto_strobes", 32'({pcLoad0, push0, pop0}), 32'h4);
        tick(); check("goto_pcload_q1", 32'(pcLoad0), 32'h0);
        check("andlw_ir", 32'(ir0), 32'hE0F);
        check("andlw_exv", 32'(exv0), 32'h0);
        instIn = 12'h2C4;                            // DECFSZ

        tick(); tick(); check("andlw_alu", 32'(alu0), 32'(A_IDLE));
        check("andlw_aluen", 32'(aluEn0), 32'h0);
        tick(); tick(); check("dfsz1_ir", 32'(ir0), 32'h2C4);
        check("dfsz1_exv", 32'(exv0), 32'h1);
        instIn = 12'h1C3;

        tick(); tick(); check("dfsz1_alu", 32'(alu0), 32'(A_DECF));
        skipCond = 1'b1;
        tick(); check("dfsz1_pcload", 32'(pcLoad0), 32'h0);
        tick(); check("skip_taken_exv", 32'(exv0), 32'h0);
        skipCond = 1'b0; instIn = 12'h2C4;

        tick(); tick(); check("skipped_aluen", 32'(aluEn0), 32'h0);
        tick(); tick(); check("dfsz2_exv", 32'(exv0), 32'h1);
        instIn = 12'h5A3;                            // BSF

        tick(); tick(); check("dfsz2_alu", 32'(alu0), 32'(A_DECF));
        tick(); tick(); check("skip_not_taken_exv", 32'(exv0), 32'h1);
        check("bsf_ir", 32'(ir0), 32'h5A3);
        instIn = 12'h4A3;                            // BCF

        tick(); tick(); check("bsf_alu", 32'(alu0), 32'(A_BSF));
        tick(); tick(); instIn = 12'h903;            // CALL
        tick(); tick(); check("bcf_alu", 32'(alu0), 32'(A_BCF));
        tick(); check("bcf_pcload", 32'(pcLoad0), 32'h0);
        tick(); check("call_ir", 32'(ir0), 32'h903);
        instIn = 12'h855;                            // RETLW, lands in NOP slot

        tick(); tick(); check("call_alu", 32'(alu0), 32'(A_IDLE));
        tick(); check("call_strobes", 32'({pcLoad0, push0, pop0}), 32'h6);
        tick(); check("retlw_exv", 32'(exv0), 32'h0);
        instIn = 12'hF55;                            // XORLW
        tick(); tick(); tick();
        check("retlw_nop_strobes", 32'({pcLoad0, push0, pop0}), 32'h0);
        tick(); check("xorlw_exv", 32'(exv0), 32'h1);
        instIn = 12'h003;                            // SLEEP

        tick(); tick(); check("xorlw_alu", 32'(alu0), 32'(A_XORLW));
        tick(); tick(); check("sleep_ir", 32'(ir0), 32'h003);
        instIn = 12'h1C3;
        tick(); tick(); tick(); check("sleep_q4_slp", 32'(slp0), 32'h0);
        tick(); check("held_ir", 32'(ir0), 32'h1C3);

`ifdef PIC_SEQ_SLEEP_EN
        check("sleeping_set", 32'(slp0), 32'h1);
        check("sleep_pcinc", 32'(pcInc0), 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("sleep_park_phase", 32'(phase0), 32'h1);
            check("sleep_park_pcinc", 32'(pcInc0), 32'h0);
        end
        wake = 1'b1;
        tick(); wake = 1'b0;
        check("wake_slp", 32'(slp0), 32'h0);
        check("wake_phase", 32'(phase0), 32'h1);
        check("wake_pcinc", 32'(pcInc0), 32'h1);
        tick(); check("wake_q2", 32'(phase0), 32'h2);
        tick(); check("wake_alu", 32'(alu0), 32'(A_ADDWF));
        check("wake_aluen", 32'(aluEn0), 32'h1);
        check("wake_exv", 32'(exv0), 32'h1);
        instIn = 12'h003;
        tick(); tick(); check("sleep2_ir", 32'(ir0), 32'h003);
        instIn = 12'h000;
        tick(); tick(); tick(); tick();
        check("sleep2_slp", 32'(slp0), 32'h1);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_sleep_slp", 32'(slp0), 32'h0);
        check("rst_sleep_phase", 32'(phase0), 32'h1);
        check("rst_sleep_exv", 32'(exv0), 32'h0);
`else
        check("nosleep_slp", 32'(slp0), 32'h0);
        check("nosleep_pcinc", 32'(pcInc0), 32'h1);
        wake = 1'b1;
        tick(); wake = 1'b0;
        check("nosleep_q2", 32'(phase0), 32'h2);
        tick(); check("nosleep_alu", 32'(alu0), 32'(A_ADDWF));
        check("nosleep_aluen", 32'(aluEn0), 32'h1);
        rst = 1'b1;
        tick();
`endif

        // WAIT_STATES=3: 7-clock cycle, Q2 held for 4 clocks
        tick();
        rst = 1'b0;
        check("ws_q1_phase", 32'(phase1), 32'h1);
        check("ws_q1_pcinc", 32'(pcInc1), 32'h1);
        for (int i = 0; i < 14; i++) begin
            tick();
            check("ws_phase", 32'(phase1), 32'(expPh[i]));
            check("ws_pcinc", 32'(pcInc1), ((i == 6) || (i == 13)) ? 32'h1 : 32'h0);
        end

        // Reset in the middle of the Q2 wait, then a fresh full-length Q2
        tick(); tick();
        rst = 1'b1;
        tick();
        check("ws_midq2_rst", 32'(phase1), 32'h1);
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        check("ws_q2_after_rst", 32'(phase1), 32'h2);
        tick();
        check("ws_q3_after_rst", 32'(phase1), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
